// File: rtl/guess_entry_pkg.sv
// Shared constants and types for the 1A2B guess-entry front end.
package guess_entry_pkg;

    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned COUNT_W   = 3;

    typedef logic [DIGIT_W-1:0]                digit_t;
    typedef logic [COUNT_W-1:0]                count_t;
    typedef logic [1:0]                        state_t;
    typedef logic [NUM_SLOTS-1:0][DIGIT_W-1:0] slots_t;

    localparam state_t ENTRY = 2'd0;
    localparam state_t FULL  = 2'd1;
    localparam state_t SEND  = 2'd2;

endpackage

// File: rtl/guess_entry_if.sv
// Keypad strobes in, guess slots and valid/ready handshake out.
interface guess_entry_if;
    import guess_entry_pkg::*;

    logic   in_key_valid;
    digit_t in_key;
    logic   in_backspace;
    logic   in_submit;
    logic   in_ready;
    digit_t out_ans0;
    digit_t out_ans1;
    digit_t out_ans2;
    digit_t out_ans3;
    count_t out_count;
    logic   out_guess_valid;
    logic   out_error;
    state_t out_state;

    modport master (
        output in_key_valid, in_key, in_backspace, in_submit, in_ready,
        input  out_ans0, out_ans1, out_ans2, out_ans3, out_count,
        input  out_guess_valid, out_error, out_state
    );

    modport slave (
        input  in_key_valid, in_key, in_backspace, in_submit, in_ready,
        output out_ans0, out_ans1, out_ans2, out_ans3, out_count,
        output out_guess_valid, out_error, out_state
    );

endinterface

// File: rtl/guess_entry_digit_dup_check.sv
// Flags a candidate digit that already sits in one of the occupied slots.
module digit_dup_check
    import guess_entry_pkg::*;
(
    input  digit_t digit_i,
    input  slots_t slots_i,
    input  count_t count_i,
    output logic   dup_o
);

    always_comb begin
        dup_o = 1'b0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if ((count_t'(i) < count_i) && (slots_i[i] == digit_i)) begin
                dup_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/guess_entry.sv
// Guess entry FSM: collects four unique digits and hands them to the core.
// Define GUESS_AUTO_SUBMIT_EN to send automatically on the fourth accepted key.
module guess_entry
    import guess_entry_pkg::*;
#(
    parameter int unsigned MAX_DIGIT   = 9,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic         in_clka,
    input  logic         in_restart,
    guess_entry_if.slave bus
);

    localparam int unsigned TmrW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYC - 1);

    state_t          state_q, state_d;
    slots_t          slots_q, slots_d;
    count_t          count_q, count_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    logic            err_q, err_d;

    logic       key_dup;
    logic       key_ok;
    logic [1:0] wr_idx;
    logic [1:0] last_idx;

    digit_dup_check u_dup (
        .digit_i (bus.in_key),
        .slots_i (slots_q),
        .count_i (count_q),
        .dup_o   (key_dup)
    );

    assign key_ok   = (32'(bus.in_key) <= MAX_DIGIT) && !key_dup;
    assign wr_idx   = count_q[1:0];
    assign last_idx = count_q[1:0] - 2'd1;

    always_ff @(posedge in_clka or posedge in_restart) begin
        if (in_restart) begin
            state_q <= ENTRY;
            slots_q <= '0;
            count_q <= '0;
            tmr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slots_q <= slots_d;
            count_q <= count_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
        end
    end

    // Strobe priority: backspace, then key, then submit.
    always_comb begin
        state_d = state_q;
        slots_d = slots_q;
        count_d = count_q;
        tmr_d   = tmr_q;
        err_d   = 1'b0;
        case (state_q)
            ENTRY: begin
                if (bus.in_backspace) begin
                    if (count_q != 3'd0) begin
                        count_d           = count_q - 3'd1;
                        slots_d[last_idx] = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.in_key_valid) begin
                    if (key_ok) begin
                        slots_d[wr_idx] = bus.in_key;
                        count_d         = count_q + 3'd1;
                        if (count_q == 3'd3) begin
`ifdef GUESS_AUTO_SUBMIT_EN
                            state_d = SEND;
                            tmr_d   = '0;
`else
                            state_d = FULL;
`endif
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.in_submit) begin
`ifndef GUESS_AUTO_SUBMIT_EN
                    err_d = 1'b1;
`endif
                end
            end
            FULL: begin
                if (bus.in_backspace) begin
                    count_d    = 3'd3;
                    slots_d[3] = '0;
                    state_d    = ENTRY;
                end else if (bus.in_key_valid) begin
                    err_d = 1'b1;
                end else if (bus.in_submit) begin
                    state_d = SEND;
                    tmr_d   = '0;
                end
            end
            SEND: begin
                // A transfer on the terminal count still counts as a transfer.
                if (bus.in_ready) begin
                    state_d = ENTRY;
                    slots_d = '0;
                    count_d = '0;
                end else if (tmr_q == TmrLast) begin
                    state_d = FULL;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            default: begin
                state_d = ENTRY;
                slots_d = '0;
                count_d = '0;
                tmr_d   = '0;
            end
        endcase
    end

    always_comb begin
        bus.out_ans0        = slots_q[0];
        bus.out_ans1        = slots_q[1];
        bus.out_ans2        = slots_q[2];
        bus.out_ans3        = slots_q[3];
        bus.out_count       = count_q;
        bus.out_guess_valid = (state_q == SEND);
        bus.out_error       = err_q;
        bus.out_state       = state_q;
    end

endmodule
